// File: rtl/pz_da_wave_gen_if.sv
// pz_da_wave_gen_if: request/done handshake and sample bus between the wave sequencer and the SPI DAC driver
interface pz_da_wave_gen_if;
  logic        da_en;
  logic [15:0] da_value;
  logic        da_done;
  logic [15:0] da_readback;
  modport master (output da_en, da_value, input da_done, da_readback);
  modport slave (input da_en, da_value, output da_done, da_readback);
endinterface

// File: rtl/pz_da_wave_gen.sv
// pz_da_wave_gen: phase-accumulator DAC sample sequencer (DC/saw/triangle/square, scale, offset, saturate)
// Optional readback compare enabled by PZ_DA_READBACK_CHECK_EN.
module pz_da_wave_gen #(
  parameter int PHASE_W     = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               da_spi_clk,
  input  logic               rst,
  input  logic               run,
  input  logic [1:0]         wave_mode,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [15:0]        amplitude,
  input  logic [15:0]        offset,
  pz_da_wave_gen_if.master   da,
  output logic [31:0]        sample_cnt,
  output logic               busy,
  output logic               timeout_err,
  output logic [15:0]        mismatch_cnt
);
  typedef enum logic [2:0] {IDLE, CALC1, CALC2, REQ, DONE} state_t;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t             state, state_nx;
  logic [PHASE_W-1:0] phase;
  logic [15:0]        p, raw, raw_nx, amp_r, off_r, value_q;
  logic [TW-1:0]      tcnt;
  logic [16:0]        sum;
  logic               tmo, start;
  assign p       = phase[PHASE_W-1 -: 16];
  assign start   = state == IDLE && run;
  assign tmo     = tcnt == TW'(TIMEOUT_CYC - 1);
  assign busy    = state != IDLE;
  assign da.da_en    = state == REQ;
  assign da.da_value = value_q;
  assign raw_nx = wave_mode == 2'd0 ? 16'hFFFF :
                  wave_mode == 2'd1 ? p :
                  wave_mode == 2'd2 ? (p[15] ? ~{p[14:0], 1'b0} : {p[14:0], 1'b0}) :
                  {16{p[15]}};
  // only the upper half of raw*amplitude is kept; 17-bit sum catches overflow for saturation
  assign sum = {1'b0, off_r} + {1'b0, 16'((32'(raw) * 32'(amp_r)) >> 16)};
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = run ? CALC1 : IDLE;
      CALC1:   state_nx = CALC2;
      CALC2:   state_nx = REQ;
      REQ:     state_nx = da.da_done ? DONE : tmo ? IDLE : REQ;
      DONE:    state_nx = run ? CALC1 : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge da_spi_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= '0;
      raw         <= '0;
      amp_r       <= '0;
      off_r       <= '0;
      value_q     <= '0;
      tcnt        <= '0;
      sample_cnt  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      tcnt  <= state == REQ ? tcnt + 1'b1 : '0;
      if (start) begin
        phase       <= '0;
        timeout_err <= 1'b0;
      end
      if (state == CALC1) begin
        raw   <= raw_nx;
        amp_r <= amplitude;
        off_r <= offset;
      end
      if (state == CALC2) value_q <= sum[16] ? 16'hFFFF : sum[15:0];
      if (state == REQ && !da.da_done && tmo) timeout_err <= 1'b1;
      if (state == DONE) begin
        sample_cnt <= sample_cnt + 1;
        phase      <= phase + phase_inc;
      end
    end
  end
`ifdef PZ_DA_READBACK_CHECK_EN
  logic [15:0] prev_q;
  logic        prev_ok;
  // the driver shifts back the word of the previous frame, so compare against the prior code
  always_ff @(posedge da_spi_clk or posedge rst) begin
    if (rst) begin
      prev_q       <= '0;
      prev_ok      <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      if (start) prev_ok <= 1'b0;
      if (state == DONE) begin
        prev_q  <= value_q;
        prev_ok <= 1'b1;
        if (prev_ok && da.da_readback != prev_q && mismatch_cnt != 16'hFFFF)
          mismatch_cnt <= mismatch_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_rb;
  assign unused_rb    = ^da.da_readback;
  assign mismatch_cnt = '0;
`endif
endmodule

// File: tb/tb_pz_da_wave_gen.sv
// tb_pz_da_wave_gen: directed self-checking bench for pz_da_wave_gen
module tb_pz_da_wave_gen;
`ifdef PZ_DA_READBACK_CHECK_EN
  localparam logic [31:0] MM_EXP = 3;
`else
  localparam logic [31:0] MM_EXP = 0;
`endif
  logic        clk = 0, rst = 1, run = 0, run_t = 0;
  logic [1:0]  wave_mode = 0;
  logic [31:0] phase_inc = 0;
  logic [15:0] amplitude = 0, offset = 0;
  logic [31:0] sample_cnt, sample_cnt_t;
  logic        busy, busy_t, terr, terr_t;
  logic [15:0] mm, mm_t;
  logic [15:0] last = 0;
  logic [15:0] tri_exp [4] = '{16'h0000, 16'h7FFF, 16'hFFFE, 16'h7FFE};
  logic [15:0] sq_exp  [4] = '{16'h0000, 16'h0000, 16'hFFFE, 16'hFFFE};
  int n_chk = 0, n_fail = 0;
  pz_da_wave_gen_if w();
  pz_da_wave_gen_if wt();
  always #5 clk = ~clk;
  pz_da_wave_gen dut (
    .da_spi_clk(clk), .rst(rst), .run(run), .wave_mode(wave_mode), .phase_inc(phase_inc),
    .amplitude(amplitude), .offset(offset), .da(w), .sample_cnt(sample_cnt),
    .busy(busy), .timeout_err(terr), .mismatch_cnt(mm)
  );
  pz_da_wave_gen #(.TIMEOUT_CYC(16)) dut_to (
    .da_spi_clk(clk), .rst(rst), .run(run_t), .wave_mode(wave_mode), .phase_inc(phase_inc),
    .amplitude(amplitude), .offset(offset), .da(wt), .sample_cnt(sample_cnt_t),
    .busy(busy_t), .timeout_err(terr_t), .mismatch_cnt(mm_t)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_en();
    int i = 0;
    while (!w.da_en && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("en_rise", 32'(w.da_en), 1);
  endtask
  task automatic xfer(input logic [15:0] exp, input int hold, input bit corrupt, input bit drop);
    int bad = 0;
    wait_en();
    if (drop) run = 0;
    repeat (hold) begin
      if (w.da_value !== exp) bad++;
      @(negedge clk);
    end
    check("value", 32'(w.da_value), 32'(exp));
    check("hold", bad, 0);
    w.da_done = 1;
    w.da_readback = corrupt ? last ^ 16'h5A5A : last;
    @(negedge clk);
    w.da_done = 0;
    check("en_fall", 32'(w.da_en), 0);
    last = exp;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int cnt;
    w.da_done = 0; w.da_readback = 0; wt.da_done = 0; wt.da_readback = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_en", 32'(w.da_en), 0);
    check("rst_value", 32'(w.da_value), 0);
    check("rst_cnt", sample_cnt, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_terr", 32'(terr), 0);
    check("rst_mm", 32'(mm), 0);
    amplitude = 16'h8000; offset = 16'h1000; run = 1;
    repeat (2) @(negedge clk);
    check("lat_lo", 32'(w.da_en), 0);
    @(negedge clk);
    check("lat_hi", 32'(w.da_en), 1);
    xfer(16'h8FFF, 20, 0, 1);
    @(negedge clk);
    check("dc_cnt", sample_cnt, 1);
    check("dc_idle", 32'(busy), 0);
    wave_mode = 1; amplitude = 16'hFFFF; offset = 0; phase_inc = 32'h1000_0000; run = 1;
    for (int k = 0; k < 17; k++)
      xfer((k % 16 == 0) ? 16'h0000 : 16'((k % 16) * 16'h1000 - 1), 1, 0, k == 16);
    @(negedge clk);
    check("saw_cnt", sample_cnt, 18);
    check("saw_idle", 32'(busy), 0);
    wave_mode = 0; offset = 16'h8000; run = 1;
    xfer(16'hFFFF, 2, 0, 1);
    @(negedge clk);
    check("sat_cnt", sample_cnt, 19);
    wave_mode = 2; offset = 0; phase_inc = 32'h4000_0000; run = 1;
    for (int k = 0; k < 4; k++) xfer(tri_exp[k], 1, 1, k == 3);
    @(negedge clk);
    wave_mode = 3; run = 1;
    for (int k = 0; k < 4; k++) xfer(sq_exp[k], 1, 0, k == 3);
    @(negedge clk);
    check("sq_cnt", sample_cnt, 27);
    check("mm_cnt", 32'(mm), MM_EXP);
    run_t = 1;
    cnt = 0;
    while (!wt.da_en && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    run_t = 0;
    cnt = 0;
    while (wt.da_en && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("to_len", cnt, 16);
    check("to_terr", 32'(terr_t), 1);
    check("to_busy", 32'(busy_t), 0);
    check("to_cnt", sample_cnt_t, 0);
    run_t = 1;
    @(negedge clk);
    check("to_clr", 32'(terr_t), 0);
    run_t = 0;
    wave_mode = 0; amplitude = 16'hFFFF; offset = 0; run = 1;
    wait_en();
    #2 rst = 1;
    #1;
    check("mid_en", 32'(w.da_en), 0);
    check("mid_value", 32'(w.da_value), 0);
    check("mid_cnt", sample_cnt, 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_terr", 32'(terr), 0);
    check("mid_mm", 32'(mm), 0);
    run = 0;
    #7 rst = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
